// File: rtl/cache_pkg.sv
// Shared types and default sizes for the direct-mapped write-through cache.
// Holds the controller state enum and default parameter constants.
package cache_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INDEX_W_DEF = 6;
  localparam int DATA_W_DEF  = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_WRITE,
    REFILL_REQ,
    REFILL_WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/Memory.sv
// Simple dual-port RAM: one write port, one read port with registered rdata.
// Ports: clk, write_en/waddr/wdata (write), raddr -> rdata (1-cycle latency).
module Memory #(
  parameter int addr_width = 6,
  parameter int data_width = 64
) (
  input  logic                  clk,
  input  logic                  write_en,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem_q [1<<addr_width];

  always_ff @(posedge clk) begin
    if (write_en) mem_q[waddr] <= wdata;
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Ports: cpu_req_*/cpu_resp_* (CPU side), mem_req_*/mem_resp_* (memory side).
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int addr_width  = ADDR_W_DEF,
  parameter int index_width = INDEX_W_DEF,
  parameter int data_width  = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_we,
  input  logic [addr_width-1:0] cpu_req_addr,
  input  logic [data_width-1:0] cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic [data_width-1:0] cpu_resp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [addr_width-1:0] mem_req_addr,
  output logic [data_width-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [data_width-1:0] mem_resp_rdata
);

  localparam int tag_width = addr_width - index_width;
  localparam int lines     = 1 << index_width;

  state_e                  state_q;
  logic [addr_width-1:0]   addr_q;
  logic                    we_q;
  logic [data_width-1:0]   wdata_q;
  logic                    resp_valid_q;
  logic [data_width-1:0]   resp_rdata_q;
  logic                    mreq_valid_q;
  logic                    mreq_we_q;
  logic [addr_width-1:0]   mreq_addr_q;
  logic [data_width-1:0]   mreq_wdata_q;
  logic [lines-1:0]        valid_q;
  logic [tag_width-1:0]    tag_q [lines];

  logic [index_width-1:0]  idx;
  logic [tag_width-1:0]    tag;
  logic                    hit;
  logic                    refill_done;
  logic                    arr_we;
  logic [data_width-1:0]   arr_wdata;
  logic [data_width-1:0]   arr_rdata;

  assign idx         = addr_q[index_width-1:0];
  assign tag         = addr_q[addr_width-1:index_width];
  assign hit         = valid_q[idx] && (tag_q[idx] == tag);
  assign refill_done = (state_q == REFILL_WAIT) && mem_resp_valid;

  // Write hits update the line in LOOKUP; refills write it on return.
  assign arr_we    = ((state_q == LOOKUP) && we_q && hit) || refill_done;
  assign arr_wdata = refill_done ? mem_resp_rdata : wdata_q;

  // Read index comes straight off the request so data is ready in LOOKUP.
  Memory #(
    .addr_width (index_width),
    .data_width (data_width)
  ) u_data (
    .clk      (clk),
    .write_en (arr_we),
    .waddr    (idx),
    .wdata    (arr_wdata),
    .raddr    (cpu_req_addr[index_width-1:0]),
    .rdata    (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (refill_done) tag_q[idx] <= tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mreq_valid_q <= 1'b0;
      mreq_we_q    <= 1'b0;
      mreq_addr_q  <= '0;
      mreq_wdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cpu_req_valid) begin
            addr_q  <= cpu_req_addr;
            we_q    <= cpu_req_we;
            wdata_q <= cpu_req_wdata;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          mreq_addr_q  <= addr_q;
          mreq_we_q    <= we_q;
          mreq_wdata_q <= wdata_q;
          if (we_q) begin
            mreq_valid_q <= 1'b1;
            state_q      <= MEM_WRITE;
          end else if (hit) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= arr_rdata;
            state_q      <= RESP;
          end else begin
            mreq_valid_q <= 1'b1;
            state_q      <= REFILL_REQ;
          end
        end
        MEM_WRITE: begin
          if (mem_req_ready) begin
            mreq_valid_q <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            state_q      <= RESP;
          end
        end
        REFILL_REQ: begin
          if (mem_req_ready) begin
            mreq_valid_q <= 1'b0;
            state_q      <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[idx] <= 1'b1;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= mem_resp_rdata;
            state_q      <= RESP;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_req_ready  = (state_q == IDLE);
  assign cpu_resp_valid = resp_valid_q;
  assign cpu_resp_rdata = resp_rdata_q;
  assign mem_req_valid  = mreq_valid_q;
  assign mem_req_we     = mreq_we_q;
  assign mem_req_addr   = mreq_addr_q;
  assign mem_req_wdata  = mreq_wdata_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: vector table plus corner sequences.
// Memory model answers reads after a programmable delay.
module tb_cache_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_we;
  logic [15:0] cpu_req_addr;
  logic [63:0] cpu_req_wdata;
  logic        cpu_resp_valid;
  logic [63:0] cpu_resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [15:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  cache_ctrl #(
    .addr_width  (16),
    .index_width (6),
    .data_width  (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [63:0] wdata;
  } mreq_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
    int          mem;
    int          lat;
  } vec_t;

  int          tests;
  int          failed;
  logic [63:0] exp_q[$];
  mreq_t       mlog[$];
  logic [63:0] bmem [0:65535];
  int          mem_delay;
  logic        pending;
  int          cnt;
  logic [15:0] paddr;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Memory model: handshake sampled mid-cycle, outputs driven after edge.
  initial begin
    logic  hs;
    mreq_t r;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    pending = 1'b0;
    cnt = 0;
    paddr = '0;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready;
      r  = '{we: mem_req_we, addr: mem_req_addr, wdata: mem_req_wdata};
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      if (pending) begin
        if (cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = bmem[paddr];
          pending = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (hs) begin
        mlog.push_back(r);
        if (r.we) begin
          bmem[r.addr] = r.wdata;
        end else begin
          pending = 1'b1;
          paddr = r.addr;
          cnt = mem_delay - 1;
        end
      end
    end
  end

  // Scoreboard: every CPU response must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && cpu_resp_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_resp: got %0h want none", cpu_resp_rdata);
        end else begin
          chk("resp_data", {64'd0, cpu_resp_rdata}, {64'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic access(input logic we, input logic [15:0] a,
                        input logic [63:0] wd, input logic [63:0] exp,
                        input int mem_e, input int lat_e);
    int base;
    int lat;
    int n;
    base = mlog.size();
    exp_q.push_back(exp);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = a;
    cpu_req_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_req_ready && n < 50);
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_resp_valid && lat < 200);
    if (!cpu_resp_valid) begin
      chk("resp_timeout", 128'(lat), 128'(0));
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #2;
    chk($sformatf("memcnt_%h", a), 128'(mlog.size() - base), 128'(mem_e));
    if (mem_e == 1 && mlog.size() > base) begin
      chk($sformatf("mreq_we_%h", a), 128'(mlog[base].we), 128'(we));
      chk($sformatf("mreq_addr_%h", a), 128'(mlog[base].addr), 128'(a));
      if (we) chk($sformatf("mreq_wdata_%h", a), 128'(mlog[base].wdata), 128'(wd));
    end
    if (lat_e != 0) chk($sformatf("lat_%h", a), 128'(lat), 128'(lat_e));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  vec_t vt[11];

  initial begin
    int          base;
    int          n;
    int          stray;
    int          got;
    logic [81:0] snap;
    tests = 0;
    failed = 0;
    mem_delay = 3;
    for (int i = 0; i < 65536; i++) bmem[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
    bmem[16'h0041] = 64'hA5A5;

    vt[0]  = '{1'b0, 16'h0041, 64'h0,    64'hA5A5,                  1, 0};
    vt[1]  = '{1'b0, 16'h0041, 64'h0,    64'hA5A5,                  0, 2};
    vt[2]  = '{1'b1, 16'h0041, 64'h1234, 64'h0,                     1, 0};
    vt[3]  = '{1'b0, 16'h0041, 64'h0,    64'h1234,                  0, 2};
    vt[4]  = '{1'b1, 16'h0082, 64'h77,   64'h0,                     1, 0};
    vt[5]  = '{1'b0, 16'h0082, 64'h0,    64'h77,                    1, 0};
    vt[6]  = '{1'b0, 16'h0005, 64'h0,    64'hDEAD_0000_0000_0005,   1, 0};
    vt[7]  = '{1'b0, 16'h0045, 64'h0,    64'hDEAD_0000_0000_0045,   1, 0};
    vt[8]  = '{1'b0, 16'h0005, 64'h0,    64'hDEAD_0000_0000_0005,   1, 0};
    vt[9]  = '{1'b0, 16'h0045, 64'h0,    64'hDEAD_0000_0000_0045,   1, 0};
    vt[10] = '{1'b0, 16'h0082, 64'h0,    64'h77,                    0, 2};

    rst = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_we = 1'b0;
    cpu_req_addr = '0;
    cpu_req_wdata = '0;
    mem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 128'(cpu_req_ready), 128'(1));
    chk("rst_resp_valid", 128'(cpu_resp_valid), 128'(0));
    chk("rst_mem_valid", 128'(mem_req_valid), 128'(0));
    chk("rst_resp_rdata", 128'(cpu_resp_rdata), 128'(0));
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++)
      access(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp, vt[i].mem, vt[i].lat);

    // Stall: memory not ready for 10 cycles on a refill request.
    mem_req_ready = 1'b0;
    fork
      access(1'b0, 16'h0010, 64'h0, 64'hDEAD_0000_0000_0010, 1, 0);
      begin
        n = 0;
        while (!mem_req_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("stall_req_seen", 128'(mem_req_valid), 128'(1));
        snap = {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata};
        chk("stall_addr", 128'(mem_req_addr), 128'(16'h0010));
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk($sformatf("stall_fields_%0d", i),
              128'({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}),
              128'(snap));
          chk($sformatf("stall_ready_%0d", i), 128'(cpu_req_ready), 128'(0));
        end
        @(posedge clk);
        #1;
        mem_req_ready = 1'b1;
      end
    join

    // Reset while waiting for refill data; late response must be ignored.
    mem_delay = 8;
    base = mlog.size();
    cpu_req_valid = 1'b1;
    cpu_req_we = 1'b0;
    cpu_req_addr = 16'h0033;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    n = 0;
    while (mlog.size() == base && n < 30) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("rw_req_seen", 128'(mlog.size() - base), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    stray = 0;
    got = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (mem_resp_valid) stray++;
      if (cpu_resp_valid) got++;
    end
    chk("stray_resp_seen", 128'(stray), 128'(1));
    chk("no_resp_after_rst", 128'(got), 128'(0));
    @(posedge clk);
    #1;
    mem_delay = 3;
    access(1'b0, 16'h0033, 64'h0, 64'hDEAD_0000_0000_0033, 1, 0);
    access(1'b0, 16'h0041, 64'h0, 64'h1234, 1, 0);
    access(1'b0, 16'h0033, 64'h0, 64'hDEAD_0000_0000_0033, 0, 2);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
